// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encoding and default width.
package div_seq_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit, subtract the
// divisor if it fits, and report the resulting quotient bit.
module div_step
  import div_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             qbit
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] diff_s;
  logic           take_s;

  assign shifted_s = {rem_in[WIDTH-1:0], dvd_msb};
  assign diff_s    = shifted_s - {1'b0, divisor};
  // A set top bit would be shifted out, so the true value certainly exceeds the divisor.
  assign take_s    = rem_in[WIDTH] | (shifted_s >= {1'b0, divisor});

  // Restore (keep the shifted value) when the divisor does not fit.
  always_comb begin
    rem_out = shifted_s;
    qbit    = 1'b0;
    if (take_s) begin
      rem_out = diff_s;
      qbit    = 1'b1;
    end else begin
      rem_out = shifted_s;
      qbit    = 1'b0;
    end
  end

endmodule

// File: rtl/div_seq.sv
// Iterative radix-2 restoring divider, signed or unsigned, one quotient bit per cycle,
// with a start/busy/done handshake.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  state_t           state_r;
  state_t           state_s;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0] dvs_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] xorig_r;
  logic [WIDTH:0]   rem_r;
  logic             xs_r;
  logic             ys_r;
  logic             zero_r;

  logic             accept_s;
  logic             xs_s;
  logic             ys_s;
  logic [WIDTH-1:0] xmag_s;
  logic [WIDTH-1:0] ymag_s;
  logic [WIDTH:0]   rem_s;
  logic             qbit_s;
  logic [WIDTH-1:0] fix_q_s;
  logic [WIDTH-1:0] fix_r_s;

  assign accept_s = (state_r == S_IDLE) && start;
  assign xs_s     = sign & x[WIDTH-1];
  assign ys_s     = sign & y[WIDTH-1];
  // Negating the most negative value yields the same pattern, read here as 2^(W-1) unsigned.
  assign xmag_s   = xs_s ? (~x + {{(WIDTH-1){1'b0}}, 1'b1}) : x;
  assign ymag_s   = ys_s ? (~y + {{(WIDTH-1){1'b0}}, 1'b1}) : y;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_in (rem_r),
    .dvd_msb(dvd_r[WIDTH-1]),
    .divisor(dvs_r),
    .rem_out(rem_s),
    .qbit   (qbit_s)
  );

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s = S_CALC;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_CALC: begin
        if (cnt_r == {CW{1'b0}}) begin
          state_s = S_FIX;
        end else begin
          state_s = S_CALC;
        end
      end
      S_FIX:   state_s = S_DONE;
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Sign fix-up of the magnitude result; division by zero overrides both values.
  always_comb begin
    fix_q_s = quo_r;
    fix_r_s = rem_r[WIDTH-1:0];
    if (zero_r) begin
      fix_q_s = {WIDTH{1'b1}};
      fix_r_s = xorig_r;
    end else begin
      fix_q_s = (xs_r ^ ys_r) ? (~quo_r + {{(WIDTH-1){1'b0}}, 1'b1}) : quo_r;
      fix_r_s = xs_r ? (~rem_r[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1}) : rem_r[WIDTH-1:0];
    end
  end

  // FSM state, step counter and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      cnt_r   <= {CW{1'b0}};
      dvd_r   <= {WIDTH{1'b0}};
      dvs_r   <= {WIDTH{1'b0}};
      quo_r   <= {WIDTH{1'b0}};
      xorig_r <= {WIDTH{1'b0}};
      rem_r   <= {(WIDTH+1){1'b0}};
      xs_r    <= 1'b0;
      ys_r    <= 1'b0;
      zero_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        cnt_r   <= CW'(WIDTH - 1);
        dvd_r   <= xmag_s;
        dvs_r   <= ymag_s;
        quo_r   <= {WIDTH{1'b0}};
        xorig_r <= x;
        rem_r   <= {(WIDTH+1){1'b0}};
        xs_r    <= xs_s;
        ys_r    <= ys_s;
        zero_r  <= (y == {WIDTH{1'b0}});
      end else if (state_r == S_CALC) begin
        cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
        dvd_r <= {dvd_r[WIDTH-2:0], 1'b0};
        rem_r <= rem_s;
        quo_r <= {quo_r[WIDTH-2:0], qbit_s};
      end else begin
        cnt_r <= cnt_r;
        dvd_r <= dvd_r;
        rem_r <= rem_r;
        quo_r <= quo_r;
      end
    end
  end

  // Registered handshake and result outputs; busy also covers the cycle that shows done.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= {WIDTH{1'b0}};
      remainder   <= {WIDTH{1'b0}};
      div_by_zero <= 1'b0;
    end else begin
      busy <= (state_s != S_IDLE) || (state_r == S_DONE);
      done <= (state_r == S_DONE);
      if (accept_s) begin
        div_by_zero <= 1'b0;
      end else if (state_r == S_FIX) begin
        quotient    <= fix_q_s;
        remainder   <= fix_r_s;
        div_by_zero <= zero_r;
      end else begin
        div_by_zero <= div_by_zero;
      end
    end
  end

endmodule
